// File: rtl/video_timing_gen.sv
// Raster timing generator for the pixel-clock domain: sync, data enable,
// active-pixel coordinates and line/frame markers, all registered one clock after the counters.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 62,
  parameter int unsigned H_BP     = 60,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 9,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 30,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             frame_seen;

  logic h_last_c;
  logic v_last_c;
  logic hs_act_c;
  logic vs_act_c;
  logic de_c;
  logic ls_c;
  logic fs_c;

  // Decode of the current counter state; registered below so all outputs stay aligned.
  always_comb begin
    h_last_c = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_last_c = (v_cnt == CNT_W'(V_TOTAL - 1));
    hs_act_c = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
    vs_act_c = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));
    de_c     = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    ls_c     = (h_cnt == '0);
    fs_c     = (h_cnt == '0) && (v_cnt == '0);
  end

  // Horizontal and vertical position counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Registered outputs; the first frame after reset leaves frame_cnt at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
      frame_seen  <= 1'b0;
    end else begin
      hsync       <= hs_act_c ? HS_POL : ~HS_POL;
      vsync       <= vs_act_c ? VS_POL : ~VS_POL;
      de          <= de_c;
      x           <= de_c ? h_cnt : '0;
      y           <= de_c ? v_cnt : '0;
      line_start  <= ls_c;
      frame_start <= fs_c;
      if (fs_c) begin
        frame_seen <= 1'b1;
        if (frame_seen) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 720x480p60 instance for line timing, small 8x6 instance
// for whole-frame raster, frame counter wrap and mid-frame reset.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_d = 1'b0;
  logic rst_s = 1'b0;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  int checks = 0;
  int errors = 0;

  // Small-instance model position, carried between tasks.
  int mh = 0, mv = 0, mfc = 0;
  bit mstarted = 0;

  always #5 clk = ~clk;

  video_timing_gen u_def (
    .clk(clk), .resetn(rst_d), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(10)
  ) u_small (
    .clk(clk), .resetn(rst_s), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  task automatic test_reset();
    logic [25:0] got;
    repeat (3) @(posedge clk);
    #1;
    // {hs,vs,de,x,y,ls,fs} then frame_cnt
    got = {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs, d_fc[2:0]};
    checks++;
    if ({d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs, d_fc} !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_default got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d (need 1 1 0 0 0 0 0 0)",
               d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs, d_fc);
    end
    checks++;
    if ({s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs, s_fc} !== {1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_small got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d (need 0 0 0 0 0 0 0 0)",
               s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs, s_fc);
    end
    if (got === 26'h0) ; // keep snapshot variable used
  endtask

  task automatic test_first_cycles();
    @(negedge clk) rst_d = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({d_de, d_x, d_y, d_fs, d_ls, d_hs, d_vs, d_fc} !== {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL first_cycle got de=%b x=%0d y=%0d fs=%b ls=%b hs=%b vs=%b fc=%0d (need 1 0 0 1 1 1 1 0)",
               d_de, d_x, d_y, d_fs, d_ls, d_hs, d_vs, d_fc);
    end
    @(posedge clk); #1;
    checks++;
    if ({d_de, d_x, d_fs, d_ls} !== {1'b1, 10'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL second_cycle got de=%b x=%0d fs=%b ls=%b (need 1 1 0 0)", d_de, d_x, d_fs, d_ls);
    end
  endtask

  task automatic test_line();
    int de_n = 0, hs_n = 0, hs_first = -1, ls_n = 0, xmax = 0, ybad = 0;
    @(negedge clk) rst_d = 1'b0;
    @(negedge clk) rst_d = 1'b1;
    for (int c = 0; c < 858; c++) begin
      @(posedge clk); #1;
      if (d_de) de_n++;
      if (!d_hs) begin
        hs_n++;
        if (hs_first < 0) hs_first = c;
      end
      if (d_ls) ls_n++;
      if (int'(d_x) > xmax) xmax = int'(d_x);
      if (d_y !== 10'd0) ybad++;
    end
    checks++;
    if (de_n != 720) begin errors++; $display("FAIL line_de_count got %0d need 720", de_n); end
    checks++;
    if (hs_n != 62) begin errors++; $display("FAIL line_hsync_width got %0d need 62", hs_n); end
    checks++;
    if (hs_first != 736) begin errors++; $display("FAIL line_hsync_start got %0d need 736", hs_first); end
    checks++;
    if (ls_n != 1) begin errors++; $display("FAIL line_start_count got %0d need 1", ls_n); end
    checks++;
    if (xmax != 719) begin errors++; $display("FAIL line_x_max got %0d need 719", xmax); end
    checks++;
    if (ybad != 0) begin errors++; $display("FAIL line_y_zero got %0d bad cycles need 0", ybad); end
    // cycle 858: start of line 1
    @(posedge clk); #1;
    checks++;
    if ({d_ls, d_fs, d_de, d_x, d_y, d_vs} !== {1'b1, 1'b0, 1'b1, 10'd0, 10'd1, 1'b1}) begin
      errors++;
      $display("FAIL line1_start got ls=%b fs=%b de=%b x=%0d y=%0d vs=%b (need 1 0 1 0 1 1)",
               d_ls, d_fs, d_de, d_x, d_y, d_vs);
    end
  endtask

  task automatic test_small_frames();
    int bad = 0;
    bit wrap_seen = 0;
    logic [7:0] prev_fc = 8'd0;
    logic [26:0] exp_v, got_v;
    @(negedge clk) rst_s = 1'b1;
    for (int c = 0; c < 260 * 48; c++) begin
      @(posedge clk); #1;
      if (mh == 0 && mv == 0) begin
        if (mstarted) mfc = (mfc + 1) % 256;
        mstarted = 1;
      end
      exp_v = {(mh >= 5 && mh <= 6), (mv == 4), (mh < 4 && mv < 3),
               (mh < 4 && mv < 3) ? 10'(mh) : 10'd0, (mh < 4 && mv < 3) ? 10'(mv) : 10'd0,
               (mh == 0), (mh == 0 && mv == 0)};
      got_v = {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs};
      checks++;
      if (got_v !== exp_v || s_fc !== 8'(mfc)) begin
        errors++;
        if (bad < 8)
          $display("FAIL small_raster cycle %0d pos (%0d,%0d) got %h fc=%0d need %h fc=%0d",
                   c, mh, mv, got_v, s_fc, exp_v, mfc);
        bad++;
      end
      if (prev_fc == 8'd255 && s_fc == 8'd0) wrap_seen = 1;
      prev_fc = s_fc;
      if (mh == 7) begin mh = 0; mv = (mv == 5) ? 0 : mv + 1; end
      else mh++;
    end
    checks++;
    if (!wrap_seen) begin errors++; $display("FAIL small_fc_wrap got no 255->0 transition need one"); end
    checks++;
    if (s_fc !== 8'd3) begin errors++; $display("FAIL small_fc_final got %0d need 3", s_fc); end
  endtask

  task automatic test_mid_reset();
    // advance to just after output position (3,2)
    while (!(mh == 4 && mv == 2)) begin
      @(posedge clk);
      if (mh == 7) begin mh = 0; mv = (mv == 5) ? 0 : mv + 1; end
      else mh++;
    end
    #1;
    checks++;
    if ({s_de, s_x, s_y} !== {1'b1, 10'd3, 10'd2}) begin
      errors++;
      $display("FAIL mid_pre_reset got de=%b x=%0d y=%0d need 1 3 2", s_de, s_x, s_y);
    end
    @(negedge clk) rst_s = 1'b0;
    #1;
    checks++;
    if ({s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs, s_fc} !== {1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset_immediate got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d need all 0",
               s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs, s_fc);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({s_de, s_x, s_fs, s_ls, s_fc} !== {1'b0, 10'd0, 1'b0, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL mid_reset_hold %0d got de=%b x=%0d fs=%b ls=%b fc=%0d need 0 0 0 0 0",
                 i, s_de, s_x, s_fs, s_ls, s_fc);
      end
    end
    @(negedge clk) rst_s = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_de, s_x, s_y, s_fs, s_ls, s_hs, s_vs, s_fc} !== {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_release_first got de=%b x=%0d y=%0d fs=%b ls=%b hs=%b vs=%b fc=%0d need 1 0 0 1 1 0 0 0",
               s_de, s_x, s_y, s_fs, s_ls, s_hs, s_vs, s_fc);
    end
    @(posedge clk); #1;
    checks++;
    if ({s_x, s_fs} !== {10'd1, 1'b0}) begin
      errors++;
      $display("FAIL mid_release_second got x=%0d fs=%b need 1 0", s_x, s_fs);
    end
    repeat (47) @(posedge clk);
    #1;
    checks++;
    if ({s_fs, s_fc} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL mid_next_frame got fs=%b fc=%0d need 1 1", s_fs, s_fc);
    end
  endtask

  initial begin
    test_reset();
    test_first_cycles();
    test_line();
    test_small_frames();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
